regfile_mem_mp: RTL and testbench

Single-clock, parametrised register-file memory, the successor to the basic dual-port register file used in the FIFO datapath. It adds NUM_RD independent read ports, per-lane write masking, a selectable read latency of 1 or 2, write-first read-during-write forwarding, out-of-range address flagging, and a hardware clear state machine. The clear machine zeroes the array after reset and on request. It serves as the storage element for the next-generation FIFO and for BIST pattern buffers.

---
 rtl/regfile_mem_mp.sv | 263 ++++++++++++++++++++++++++
 tb/tb_regfile_mem_mp.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mem_mp.sv
// regfile_mem_mp
//   Single-clock register-file memory with NUM_RD independent read ports,
//   per-lane write masking, read latency 1 or 2, write-first forwarding,
//   out-of-range flagging and a clear state machine that zeroes the array
//   after reset and on request.
//
// Ports
//   CLK, RST_N     clock (rising edge), asynchronous active-low reset
//   CLR_REQ        request a full-array clear (ignored while BUSY)
//   BUSY           high while the clear machine runs
//   DBG_STATE      raw FSM state (0 = CLEAR, 1 = IDLE)
//   W_EN/W_MASK/W_ADDR/W_DATA  write port, W_MASK has one bit per lane
//   W_ERR          one-cycle pulse after a write to an address >= DEPTH
//   R_EN/R_ADDR    per-port read request, addresses packed ADDR_WIDTH each
//   R_DATA/R_VALID/R_ERR  per-port read result, valid pulse, range error
//
// Optional feature (macro REGFILE_PARITY_EN)
//   Adds a per-lane even-parity bit, input FORCE_PAR_ERR (invert stored
//   parity of written lanes) and output PAR_ERR (per port, aligned with
//   R_VALID, 0 on out-of-range reads).
//
// Handshake: there is no backpressure. A read is accepted on every edge
// where R_EN[p] is high and BUSY is low; its result is announced by a
// single-cycle R_VALID[p] pulse RD_LAT cycles later. R_DATA[p] only changes
// together with R_VALID[p] and holds otherwise.
module regfile_mem_mp #(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_W     = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 10,
  parameter int NUM_RD     = 2,
  parameter int RD_LAT     = 1,
  localparam int NUM_LANES = DATA_WIDTH / LANE_W
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         CLR_REQ,
  output logic                         BUSY,
  output logic                         DBG_STATE,
  input  logic                         W_EN,
  input  logic [NUM_LANES-1:0]         W_MASK,
  input  logic [ADDR_WIDTH-1:0]        W_ADDR,
  input  logic [DATA_WIDTH-1:0]        W_DATA,
  output logic                         W_ERR,
`ifdef REGFILE_PARITY_EN
  input  logic                         FORCE_PAR_ERR,
  output logic [NUM_RD-1:0]            PAR_ERR,
`endif
  input  logic [NUM_RD-1:0]            R_EN,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] R_ADDR,
  output logic [NUM_RD*DATA_WIDTH-1:0] R_DATA,
  output logic [NUM_RD-1:0]            R_VALID,
  output logic [NUM_RD-1:0]            R_ERR
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_ptr, w_clr_ptr_nxt;
  logic                    w_idle;

  // ---------------- clear FSM ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      S_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == LAST_ADDR) begin
          w_state_nxt   = S_IDLE;
          w_clr_ptr_nxt = '0;
        end
      end
      S_IDLE: begin
        if (CLR_REQ) begin
          w_state_nxt   = S_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = S_CLEAR;
        w_clr_ptr_nxt = '0;
      end
    endcase
  end

  assign w_idle    = (r_state == S_IDLE);
  assign BUSY      = (r_state == S_CLEAR);
  assign DBG_STATE = r_state;

  // ---------------- storage ----------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_wr_in_range;
  logic                  w_wr_ok;

  assign w_wr_in_range = ({1'b0, W_ADDR} < DEPTH_C);
  assign w_wr_ok       = w_idle && W_EN && w_wr_in_range;

`ifdef REGFILE_PARITY_EN
  logic [NUM_LANES-1:0] r_par [DEPTH];
  logic [NUM_LANES-1:0] w_wr_par;

  always_comb begin
    w_wr_par = '0;
    for (int i = 0; i < NUM_LANES; i++)
      w_wr_par[i] = (^W_DATA[i*LANE_W +: LANE_W]) ^ FORCE_PAR_ERR;
  end
`endif

  // The array has no reset; the clear machine owns it while BUSY.
  always_ff @(posedge CLK) begin
    if (BUSY) begin
      r_mem[r_clr_ptr] <= '0;
`ifdef REGFILE_PARITY_EN
      r_par[r_clr_ptr] <= '0;
`endif
    end else if (w_wr_ok) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (W_MASK[i]) begin
          r_mem[W_ADDR][i*LANE_W +: LANE_W] <= W_DATA[i*LANE_W +: LANE_W];
`ifdef REGFILE_PARITY_EN
          r_par[W_ADDR][i] <= w_wr_par[i];
`endif
        end
      end
    end
  end

  // ---------------- read, first stage ----------------
  // Write-first: lanes being written on this edge are taken from W_DATA.
  logic [NUM_RD-1:0]     w_rd_ok;
  logic [DATA_WIDTH-1:0] w_rd_data [NUM_RD];
`ifdef REGFILE_PARITY_EN
  logic [NUM_RD-1:0]     w_rd_perr;
`endif

  always_comb begin
`ifdef REGFILE_PARITY_EN
    logic [NUM_LANES-1:0] w_par_st;
    w_par_st  = '0;
    w_rd_perr = '0;
`endif
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd_ok[p]   = ({1'b0, R_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_C);
      w_rd_data[p] = '0;
      if (w_rd_ok[p]) begin
        w_rd_data[p] = r_mem[R_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_PARITY_EN
        w_par_st = r_par[R_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH]];
`endif
        for (int i = 0; i < NUM_LANES; i++) begin
          if (w_wr_ok && W_MASK[i] && (W_ADDR == R_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
            w_rd_data[p][i*LANE_W +: LANE_W] = W_DATA[i*LANE_W +: LANE_W];
`ifdef REGFILE_PARITY_EN
            w_par_st[i] = w_wr_par[i];
`endif
          end
        end
`ifdef REGFILE_PARITY_EN
        for (int i = 0; i < NUM_LANES; i++)
          if ((^w_rd_data[p][i*LANE_W +: LANE_W]) != w_par_st[i])
            w_rd_perr[p] = 1'b1;
`endif
      end
    end
  end

  logic [NUM_RD-1:0]     r_v1, r_e1;
  logic [DATA_WIDTH-1:0] r_d1 [NUM_RD];
  logic                  r_w_err;
`ifdef REGFILE_PARITY_EN
  logic [NUM_RD-1:0]     r_pe1;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_v1    <= '0;
      r_e1    <= '0;
      r_w_err <= 1'b0;
      for (int p = 0; p < NUM_RD; p++) r_d1[p] <= '0;
`ifdef REGFILE_PARITY_EN
      r_pe1   <= '0;
`endif
    end else begin
      r_w_err <= w_idle && W_EN && !w_wr_in_range;
      for (int p = 0; p < NUM_RD; p++) begin
        r_v1[p] <= w_idle && R_EN[p];
        r_e1[p] <= w_idle && R_EN[p] && !w_rd_ok[p];
        if (w_idle && R_EN[p]) r_d1[p] <= w_rd_data[p];
`ifdef REGFILE_PARITY_EN
        r_pe1[p] <= w_idle && R_EN[p] && w_rd_perr[p];
`endif
      end
    end
  end

  assign W_ERR = r_w_err;

  // ---------------- optional output register ----------------
  // Stage two only re-times stage one, so later writes cannot touch data
  // already in flight.
  if (RD_LAT == 2) begin : g_lat2
    logic [NUM_RD-1:0]     r_v2, r_e2;
    logic [DATA_WIDTH-1:0] r_d2 [NUM_RD];
`ifdef REGFILE_PARITY_EN
    logic [NUM_RD-1:0]     r_pe2;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_v2 <= '0;
        r_e2 <= '0;
        for (int p = 0; p < NUM_RD; p++) r_d2[p] <= '0;
`ifdef REGFILE_PARITY_EN
        r_pe2 <= '0;
`endif
      end else begin
        r_v2 <= r_v1;
        r_e2 <= r_e1;
        for (int p = 0; p < NUM_RD; p++)
          if (r_v1[p]) r_d2[p] <= r_d1[p];
`ifdef REGFILE_PARITY_EN
        r_pe2 <= r_pe1;
`endif
      end
    end

    always_comb begin
      R_VALID = r_v2;
      R_ERR   = r_e2;
      R_DATA  = '0;
      for (int p = 0; p < NUM_RD; p++) R_DATA[p*DATA_WIDTH +: DATA_WIDTH] = r_d2[p];
    end
`ifdef REGFILE_PARITY_EN
    assign PAR_ERR = r_pe2;
`endif
  end else begin : g_lat1
    always_comb begin
      R_VALID = r_v1;
      R_ERR   = r_e1;
      R_DATA  = '0;
      for (int p = 0; p < NUM_RD; p++) R_DATA[p*DATA_WIDTH +: DATA_WIDTH] = r_d1[p];
    end
`ifdef REGFILE_PARITY_EN
    assign PAR_ERR = r_pe1;
`endif
  end

endmodule

// File: tb/tb_regfile_mem_mp.sv
// Bench for regfile_mem_mp: two instances (RD_LAT=1 and RD_LAT=2) share
// every input. A behavioural model (plain array plus a result delay line)
// predicts the outputs of both each cycle; directed sequences add literal
// expectations for the key scenarios.
module tb_regfile_mem_mp;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 10;
  localparam int NRD = 2;
  localparam int RW = DW + 2; // per-port result word {valid, err, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            clr_req = 1'b0;
  logic            w_en = 1'b0;
  logic [1:0]      w_mask = 2'b00;
  logic [AW-1:0]   w_addr = '0;
  logic [DW-1:0]   w_data = '0;
  logic [NRD-1:0]  r_en = '0;
  logic [NRD*AW-1:0] r_addr = '0;
`ifdef REGFILE_PARITY_EN
  logic            force_par = 1'b0;
  logic [NRD-1:0]  par1, par2;
`endif

  logic busy1, busy2, dbg1, dbg2, werr1, werr2;
  logic [NRD*DW-1:0] rdata1, rdata2;
  logic [NRD-1:0]    rvalid1, rvalid2, rerr1, rerr2;

  regfile_mem_mp #(.DATA_WIDTH(DW), .LANE_W(8), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                   .NUM_RD(NRD), .RD_LAT(1)) u_l1 (
    .CLK(clk), .RST_N(rst_n), .CLR_REQ(clr_req), .BUSY(busy1), .DBG_STATE(dbg1),
    .W_EN(w_en), .W_MASK(w_mask), .W_ADDR(w_addr), .W_DATA(w_data), .W_ERR(werr1),
`ifdef REGFILE_PARITY_EN
    .FORCE_PAR_ERR(force_par), .PAR_ERR(par1),
`endif
    .R_EN(r_en), .R_ADDR(r_addr), .R_DATA(rdata1), .R_VALID(rvalid1), .R_ERR(rerr1));

  regfile_mem_mp #(.DATA_WIDTH(DW), .LANE_W(8), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                   .NUM_RD(NRD), .RD_LAT(2)) u_l2 (
    .CLK(clk), .RST_N(rst_n), .CLR_REQ(clr_req), .BUSY(busy2), .DBG_STATE(dbg2),
    .W_EN(w_en), .W_MASK(w_mask), .W_ADDR(w_addr), .W_DATA(w_data), .W_ERR(werr2),
`ifdef REGFILE_PARITY_EN
    .FORCE_PAR_ERR(force_par), .PAR_ERR(par2),
`endif
    .R_EN(r_en), .R_ADDR(r_addr), .R_DATA(rdata2), .R_VALID(rvalid2), .R_ERR(rerr2));

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0]     m_mem [DEPTH];
  int                m_clr_left;
  logic              m_busy, m_werr;
  logic [NRD-1:0]    e1_v, e1_e, e2_v, e2_e;
  logic [NRD*DW-1:0] e1_d, e2_d;
  logic [NRD*RW-1:0] exp_q[$]; // results of the last two edges, newest last

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [1:0] mask);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < 2; i++) if (mask[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_clr_left = DEPTH;
    m_busy = 1'b1;
    m_werr = 1'b0;
    e1_v = '0; e1_e = '0; e1_d = '0;
    e2_v = '0; e2_e = '0; e2_d = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [NRD*RW-1:0] res, old;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    res = '0;
    if (m_clr_left > 0) begin
      m_mem[DEPTH - m_clr_left] = '0;
      m_clr_left--;
      m_werr = 1'b0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        if (r_en[p]) begin
          a = r_addr[p*AW +: AW];
          if (a >= DEPTH) res[p*RW +: RW] = {2'b11, 16'h0000};
          else begin
            d = m_mem[a];
            if (w_en && w_addr == a) d = merge(d, w_data, w_mask);
            res[p*RW +: RW] = {2'b10, d};
          end
        end
      end
      m_werr = w_en && (w_addr >= DEPTH);
      if (w_en && w_addr < DEPTH) m_mem[w_addr] = merge(m_mem[w_addr], w_data, w_mask);
      if (clr_req) m_clr_left = DEPTH;
    end
    exp_q.push_back(res);
    if (exp_q.size() > 2) void'(exp_q.pop_front());
    old = (exp_q.size() == 2) ? exp_q[0] : '0;
    for (int p = 0; p < NRD; p++) begin
      e1_v[p] = res[p*RW + DW + 1];
      e1_e[p] = res[p*RW + DW];
      if (e1_v[p]) e1_d[p*DW +: DW] = res[p*RW +: DW];
      e2_v[p] = old[p*RW + DW + 1];
      e2_e[p] = old[p*RW + DW];
      if (e2_v[p]) e2_d[p*DW +: DW] = old[p*RW +: DW];
    end
    m_busy = (m_clr_left > 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("L1 busy",  32'(busy1),   32'(m_busy));
      check("L2 busy",  32'(busy2),   32'(m_busy));
      check("L1 state", 32'(dbg1),    32'(!m_busy));
      check("L1 w_err", 32'(werr1),   32'(m_werr));
      check("L2 w_err", 32'(werr2),   32'(m_werr));
      check("L1 valid", 32'(rvalid1), 32'(e1_v));
      check("L1 r_err", 32'(rerr1),   32'(e1_e));
      check("L1 data",  rdata1,       e1_d);
      check("L2 valid", 32'(rvalid2), 32'(e2_v));
      check("L2 r_err", 32'(rerr2),   32'(e2_e));
      check("L2 data",  rdata2,       e2_d);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
    w_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
    cyc();
    w_en = 1'b0;
  endtask

  // Count cycles with BUSY high, starting with the current one.
  task automatic count_busy(input string name, input bit pulse_clr);
    int n;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (!busy1) break;
      n++;
      clr_req = pulse_clr && (n == 3);
      cyc();
    end
    clr_req = 1'b0;
    check(name, 32'(n), 32'd10);
  endtask

  task automatic read_sweep(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      r_en = 2'b11;
      r_addr = {4'(9 - a), 4'(a)};
      cyc();
      check(name, rdata1, 32'h0);
    end
    r_en = 2'b00;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset with W_EN and both R_EN held: nothing may be written or read.
    w_en = 1'b1; w_mask = 2'b11; w_data = 16'hFFFF; w_addr = 4'd0;
    r_en = 2'b11; r_addr = '0;
    repeat (3) cyc();
    check("reset busy", 32'(busy1), 32'd1);
    check("reset valid", 32'({rvalid1, rvalid2}), 32'd0);
    rst_n = 1'b1;
    count_busy("busy after reset", 1'b0);
    w_en = 1'b0;
    r_en = 2'b00;
    read_sweep("post-reset sweep");

    // Same address on both ports, both latencies.
    write(4'd3, 16'h00A5, 2'b11);
    r_en = 2'b11; r_addr = {4'd3, 4'd3};
    cyc();
    r_en = 2'b00;
    check("dual read L1 data", rdata1, 32'h00A5_00A5);
    check("dual read L1 valid", 32'(rvalid1), 32'h3);
    check("dual read L2 early", 32'(rvalid2), 32'h0);
    cyc();
    check("dual read L2 data", rdata2, 32'h00A5_00A5);
    check("dual read L2 valid", 32'(rvalid2), 32'h3);
    check("dual read L1 pulse", 32'(rvalid1), 32'h0);

    // Masked write-first forwarding.
    write(4'd5, 16'h1234, 2'b11);
    w_en = 1'b1; w_addr = 4'd5; w_data = 16'hABCD; w_mask = 2'b01;
    r_en = 2'b01; r_addr = {4'd0, 4'd5};
    cyc();
    w_en = 1'b0;
    check("fwd L1 data", 32'(rdata1[15:0]), 32'h12CD);
    cyc();
    r_en = 2'b00;
    check("fwd stored", 32'(rdata1[15:0]), 32'h12CD);
    check("fwd L2 data", 32'(rdata2[15:0]), 32'h12CD);

    // Upper-lane only write.
    write(4'd8, 16'hBEEF, 2'b10);
    r_en = 2'b10; r_addr = {4'd8, 4'd0};
    cyc();
    r_en = 2'b00;
    check("upper lane", 32'(rdata1[31:16]), 32'hBE00);

    // Out-of-range write and read.
    w_en = 1'b1; w_addr = 4'd12; w_data = 16'hFFFF; w_mask = 2'b11;
    r_en = 2'b10; r_addr = {4'd15, 4'd0};
    cyc();
    w_en = 1'b0; r_en = 2'b00;
    check("oor w_err", 32'(werr1), 32'd1);
    check("oor r_err", 32'(rerr1), 32'h2);
    check("oor valid", 32'(rvalid1), 32'h2);
    check("oor data", 32'(rdata1[31:16]), 32'h0);
    cyc();
    check("oor w_err pulse", 32'(werr1), 32'd0);
    r_en = 2'b11; r_addr = {4'd4, 4'd2};
    cyc();
    r_en = 2'b00;
    check("oor no alias", rdata1, 32'h0);

    // Zero mask is a no-op without error.
    write(4'd3, 16'h0000, 2'b00);
    check("mask0 w_err", 32'(werr1), 32'd0);
    r_en = 2'b01; r_addr = {4'd0, 4'd3};
    cyc();
    r_en = 2'b00;
    check("mask0 data", 32'(rdata1[15:0]), 32'h00A5);

    // Latency-2 in-flight data is not altered by a following write.
    write(4'd7, 16'h0707, 2'b11);
    r_en = 2'b01; r_addr = {4'd0, 4'd7};
    cyc();
    r_en = 2'b00;
    w_en = 1'b1; w_addr = 4'd7; w_data = 16'h0808; w_mask = 2'b11;
    cyc();
    w_en = 1'b0;
    check("inflight L2", 32'(rdata2[15:0]), 32'h0707);

    // Requested clear with a re-request and writes while busy.
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    w_en = 1'b1; w_addr = 4'd3; w_data = 16'h7777; w_mask = 2'b11;
    count_busy("busy on clear", 1'b1);
    w_en = 1'b0;
    read_sweep("post-clear sweep");

    // Reset in the middle of a clear restarts it.
    write(4'd9, 16'h5555, 2'b11);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    check("mid-clear reset valid", 32'(rvalid1), 32'd0);
    rst_n = 1'b1;
    count_busy("busy after restart", 1'b0);
    r_en = 2'b10; r_addr = {4'd9, 4'd0};
    cyc();
    r_en = 2'b00;
    check("restart cleared", 32'(rdata1[31:16]), 32'h0);

`ifdef REGFILE_PARITY_EN
    force_par = 1'b1;
    write(4'd2, 16'h003C, 2'b11);
    force_par = 1'b0;
    r_en = 2'b01; r_addr = {4'd0, 4'd2};
    cyc();
    r_en = 2'b00;
    check("forced parity", 32'(par1[0]), 32'd1);
    check("forced parity data", 32'(rdata1[15:0]), 32'h003C);
    write(4'd2, 16'h003C, 2'b11);
    r_en = 2'b01;
    cyc();
    r_en = 2'b00;
    check("clean parity", 32'(par1), 32'd0);
`endif

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
